imm_ext_arbiter: RTL and testbench



---
 rtl/imm_ext_pkg.sv | 32 +++
 rtl/imm_field_decode.sv | 42 ++++
 rtl/imm_ext_arbiter.sv | 128 ++++++++++++
 tb/tb_imm_ext_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared constants and types for the immediate-extender arbiter.
package imm_ext_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned IMM12_W = 12;
  localparam int unsigned IMM20_W = 20;
  localparam int unsigned OPC_W   = 7;

  localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    CTRL_I12 = 2'b00,
    CTRL_B13 = 2'b01,
    CTRL_U20 = 2'b10,
    CTRL_J21 = 2'b11
  } ext_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXT  = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/imm_field_decode.sv
// Slices the RISC-V immediate fields of one instruction and selects the extender mode.
module imm_field_decode
  import imm_ext_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [IMM12_W-1:0] imm12,
  output logic [IMM20_W-1:0] imm20,
  output ext_ctrl_e          ctrl,
  output logic               u_shift,
  output logic               err
);

  // Unknown opcodes fall back to I-type slicing so the extender sees a defined input.
  always_comb begin
    imm12   = instr[31:20];
    imm20   = '0;
    ctrl    = CTRL_I12;
    u_shift = 1'b0;
    err     = 1'b0;
    case (instr[OPC_W-1:0])
      OP_IMM, LOAD, JALR: ;
      STORE: imm12 = {instr[31:25], instr[11:7]};
      BRANCH: begin
        imm12 = {instr[31], instr[7], instr[30:25], instr[11:8]};
        ctrl  = CTRL_B13;
      end
      LUI, AUIPC: begin
        imm12   = '0;
        imm20   = instr[31:12];
        ctrl    = CTRL_U20;
        u_shift = 1'b1;
      end
      JAL: begin
        imm12 = '0;
        imm20 = {instr[31], instr[19:12], instr[20], instr[30:21]};
        ctrl  = CTRL_J21;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin share of one external sign-extender between two decode stages,
// with a registered result returned over a valid/ready handshake.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr_i,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag_i,
  output logic [NUM_REQ-1:0]         resp_valid_o,
  input  logic [NUM_REQ-1:0]         resp_ready_i,
  output logic [IMM_W-1:0]           resp_imm_o,
  output logic [TAG_W-1:0]           resp_tag_o,
  output logic                       resp_err_o,
  output logic [IMM12_W-1:0]         ext_imm12_o,
  output logic [IMM20_W-1:0]         ext_imm20_o,
  output logic [1:0]                 ext_ctrl_o,
  input  logic [IMM_W-1:0]           ext_imm32_i
);

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;
  logic                 win_q, win_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [IMM_W-1:0]     imm_q, imm_d;
  logic                 err_q, err_d;
  logic [NUM_REQ-1:0]   grant;

  logic [IMM12_W-1:0]   dec_imm12;
  logic [IMM20_W-1:0]   dec_imm20;
  ext_ctrl_e            dec_ctrl;
  logic                 dec_u_shift;
  logic                 dec_err;

  // Decode always runs on the latched instruction, so ext outputs only change on a grant.
  imm_field_decode u_decode (
    .instr   (instr_q),
    .imm12   (dec_imm12),
    .imm20   (dec_imm20),
    .ctrl    (dec_ctrl),
    .u_shift (dec_u_shift),
    .err     (dec_err)
  );

  // Single requester wins outright; on contention rr_q picks the winner.
  always_comb begin
    grant = '0;
    case (req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    instr_d = instr_q;
    tag_d   = tag_q;
    imm_d   = imm_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant != '0) begin
          win_d   = grant[1];
          rr_d    = ~grant[1];
          instr_d = grant[1] ? req_instr_i[INSTR_W +: INSTR_W] : req_instr_i[0 +: INSTR_W];
          tag_d   = grant[1] ? req_tag_i[TAG_W +: TAG_W] : req_tag_i[0 +: TAG_W];
          state_d = EXT;
        end
      end
      EXT: begin
        // U-type: extender returns the raw 20-bit field; the upper placement happens here.
        if (dec_err)
          imm_d = '0;
        else if (dec_u_shift)
          imm_d = {ext_imm32_i[IMM20_W-1:0], 12'h000};
        else
          imm_d = ext_imm32_i;
        err_d   = dec_err;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i[win_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      win_q   <= 1'b0;
      instr_q <= '0;
      tag_q   <= '0;
      imm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      instr_q <= instr_d;
      tag_q   <= tag_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE) ? grant : '0;
  assign resp_valid_o = (state_q == RESP) ? {win_q, ~win_q} : '0;
  assign resp_imm_o   = imm_q;
  assign resp_tag_o   = tag_q;
  assign resp_err_o   = err_q;
  assign ext_imm12_o  = dec_imm12;
  assign ext_imm20_o  = dec_imm20;
  assign ext_ctrl_o   = dec_ctrl;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench: directed vector table, stall/fairness/reset sequences and
// randomized traffic against an ISA-level immediate model.
module tb_imm_ext_arbiter;

  localparam int unsigned TW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid_i;
  logic [1:0]    req_ready_o;
  logic [63:0]   req_instr_i;
  logic [2*TW-1:0] req_tag_i;
  logic [1:0]    resp_valid_o;
  logic [1:0]    resp_ready_i;
  logic [31:0]   resp_imm_o;
  logic [TW-1:0] resp_tag_o;
  logic          resp_err_o;
  logic [11:0]   ext_imm12_o;
  logic [19:0]   ext_imm20_o;
  logic [1:0]    ext_ctrl_o;
  logic [31:0]   ext_imm32_i;

  always #5 clk = ~clk;

  // Behaviour of the external sign-extender beside the arbiter.
  always_comb begin
    case (ext_ctrl_o)
      2'b00:   ext_imm32_i = {{20{ext_imm12_o[11]}}, ext_imm12_o};
      2'b01:   ext_imm32_i = {{19{ext_imm12_o[11]}}, ext_imm12_o, 1'b0};
      2'b10:   ext_imm32_i = {{12{ext_imm20_o[19]}}, ext_imm20_o};
      default: ext_imm32_i = {{11{ext_imm20_o[19]}}, ext_imm20_o, 1'b0};
    endcase
  end

  imm_ext_arbiter #(.NUM_REQ(2), .TAG_W(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_instr_i  (req_instr_i),
    .req_tag_i    (req_tag_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_imm_o   (resp_imm_o),
    .resp_tag_o   (resp_tag_o),
    .resp_err_o   (resp_err_o),
    .ext_imm12_o  (ext_imm12_o),
    .ext_imm20_o  (ext_imm20_o),
    .ext_ctrl_o   (ext_ctrl_o),
    .ext_imm32_i  (ext_imm32_i)
  );

  int   errors = 0;
  int   checks = 0;
  logic exp_rr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Architectural RISC-V immediate value and extender mode for one instruction.
  function automatic void ref_imm(input logic [31:0] ins, output logic [31:0] imm,
                                  output logic err, output logic [1:0] ctrl);
    err = 1'b0; ctrl = 2'b00; imm = '0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: imm = {{20{ins[31]}}, ins[31:20]};
      7'h23: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'h63: begin imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; ctrl = 2'b01; end
      7'h37, 7'h17: begin imm = {ins[31:12], 12'h000}; ctrl = 2'b10; end
      7'h6f: begin imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; ctrl = 2'b11; end
      default: err = 1'b1;
    endcase
  endfunction

  // One request/response transaction with full handshake checks.
  task automatic transact(input string nm, input logic [1:0] vmask,
                          input logic [31:0] i0, input logic [31:0] i1,
                          input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                          input int stall, input logic keep_loser, input logic other_rdy,
                          input logic exp_win, input logic [31:0] exp_imm,
                          input logic exp_err, input logic [1:0] exp_ctrl);
    int n;
    logic [1:0] oh;
    logic [TW-1:0] exp_tag;
    oh      = exp_win ? 2'b10 : 2'b01;
    exp_tag = exp_win ? t1 : t0;
    @(negedge clk);
    req_valid_i = vmask;
    req_instr_i = {i1, i0};
    req_tag_i   = {t1, t0};
    resp_ready_i = '0;
    resp_ready_i[exp_win]  = (stall == 0);
    resp_ready_i[~exp_win] = other_rdy;
    #1;
    n = 0;
    while (req_ready_o == 2'b00 && n < 8) begin @(negedge clk); #1; n++; end
    check({nm, " grant"}, 32'(req_ready_o), 32'(oh));
    if (req_ready_o == 2'b00) begin
      req_valid_i = '0;
      return;
    end
    @(posedge clk);
    #1;
    exp_rr = ~exp_win;
    req_valid_i = (keep_loser && vmask == 2'b11) ? ~oh : 2'b00;
    @(negedge clk);
    check({nm, " ext_ctrl"}, 32'(ext_ctrl_o), 32'(exp_ctrl));
    check({nm, " unused_field"}, exp_ctrl[1] ? 32'(ext_imm12_o) : 32'(ext_imm20_o), 32'h0);
    check({nm, " ext_phase_valid"}, 32'(resp_valid_o), 32'h0);
    n = 0;
    while (resp_valid_o == 2'b00 && n < 8) begin @(negedge clk); n++; end
    check({nm, " latency"}, 32'(n), 32'd1);
    check({nm, " resp_valid"}, 32'(resp_valid_o), 32'(oh));
    check({nm, " imm"}, resp_imm_o, exp_imm);
    check({nm, " tag"}, 32'(resp_tag_o), 32'(exp_tag));
    check({nm, " err"}, 32'(resp_err_o), 32'(exp_err));
    check({nm, " busy_ready"}, 32'(req_ready_o), 32'h0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({nm, " stall_valid"}, 32'(resp_valid_o), 32'(oh));
      check({nm, " stall_imm"}, resp_imm_o, exp_imm);
      check({nm, " stall_ready"}, 32'(req_ready_o), 32'h0);
    end
    resp_ready_i[exp_win] = 1'b1;
    @(posedge clk);
    #1;
    check({nm, " resp_done"}, 32'(resp_valid_o), 32'h0);
    resp_ready_i = '0;
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  vmask;
    logic [31:0] i0, i1;
    logic [TW-1:0] t0, t1;
    int          stall;
    logic        keep;
    logic        other_rdy;
    logic        win;
    logic [31:0] imm;
    logic        err;
    logic [1:0]  ctrl;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins, r, eimm;
    logic        eerr, ewin;
    logic [1:0]  ectrl, vm;
    logic [6:0]  ops [10];
    logic [TW-1:0] rt0, rt1;
    int          first;

    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f};

    vecs.push_back('{"stall_c0",  2'b11, 32'hFFF00093, 32'h00100093, 5'd1, 5'd2, 3, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 2'b00});
    vecs.push_back('{"after_c1",  2'b10, 32'hFFF00093, 32'h00100093, 5'd1, 5'd2, 0, 1'b0, 1'b0, 1'b1, 32'h00000001, 1'b0, 2'b00});
    vecs.push_back('{"addi",      2'b01, 32'hFFF00093, 32'h0,        5'd1, 5'd0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 2'b00});
    vecs.push_back('{"beq",       2'b10, 32'h0,        32'hFE000EE3, 5'd0, 5'd9, 0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 2'b01});
    vecs.push_back('{"lui",       2'b01, 32'h123452B7, 32'h0,        5'd5, 5'd0, 0, 1'b0, 1'b0, 1'b0, 32'h12345000, 1'b0, 2'b10});
    vecs.push_back('{"jal",       2'b01, 32'h008000EF, 32'h0,        5'd1, 5'd0, 1, 1'b0, 1'b1, 1'b0, 32'h00000008, 1'b0, 2'b11});
    vecs.push_back('{"rr_c1",     2'b11, 32'h00C52503, 32'hFE512C23, 5'd10, 5'd3, 0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 1'b0, 2'b00});
    vecs.push_back('{"auipc",     2'b10, 32'h0,        32'hFFFFF097, 5'd0, 5'd1, 2, 1'b0, 1'b1, 1'b1, 32'hFFFFF000, 1'b0, 2'b10});
    vecs.push_back('{"jalr",      2'b01, 32'h800000E7, 32'h0,        5'd1, 5'd0, 0, 1'b0, 1'b0, 1'b0, 32'hFFFFF800, 1'b0, 2'b00});
    vecs.push_back('{"rtype_err", 2'b01, 32'h00000033, 32'h0,        5'd7, 5'd0, 0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00});

    rst_n = 1'b0; req_valid_i = '0; req_instr_i = '0; req_tag_i = '0; resp_ready_i = '0;
    exp_rr = 1'b0;
    #3;
    check("rst ready", 32'(req_ready_o), 32'h0);
    check("rst valid", 32'(resp_valid_o), 32'h0);
    check("rst imm", resp_imm_o, 32'h0);
    check("rst tag_err", {26'h0, resp_tag_o, resp_err_o}, 32'h0);
    check("rst ext", {ext_imm12_o, ext_imm20_o}, 32'h0);
    check("rst ctrl", 32'(ext_ctrl_o), 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k])
      transact(vecs[k].nm, vecs[k].vmask, vecs[k].i0, vecs[k].i1, vecs[k].t0, vecs[k].t1,
               vecs[k].stall, vecs[k].keep, vecs[k].other_rdy, vecs[k].win,
               vecs[k].imm, vecs[k].err, vecs[k].ctrl);

    // Fairness: both cores valid every round, grants must alternate.
    first = int'(exp_rr);
    for (int k = 0; k < 4; k++) begin
      ins = 32'h00500093 + 32'(k << 20);
      ref_imm(ins, eimm, eerr, ectrl);
      ewin = 1'((first + k) % 2);
      transact("fair", 2'b11, ins, ins, 5'(k), 5'(k + 16), 0, 1'b1, 1'b1, ewin, eimm, eerr, ectrl);
    end

    // Reset while a response is stalled drops it without a later pulse.
    @(negedge clk);
    req_valid_i = 2'b01; req_instr_i = {32'h0, 32'hFFF00093}; req_tag_i = '0; resp_ready_i = 2'b00;
    #1;
    check("rstseq grant", 32'(req_ready_o), 32'h1);
    @(posedge clk); #1; req_valid_i = '0;
    @(negedge clk); @(negedge clk);
    check("rstseq valid", 32'(resp_valid_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rstseq drop", 32'(resp_valid_o), 32'h0);
    check("rstseq imm", resp_imm_o, 32'h0);
    check("rstseq ready", 32'(req_ready_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; resp_ready_i = 2'b11; exp_rr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rstseq no_resp", 32'(resp_valid_o), 32'h0);
    end

    // Randomized traffic against the ISA-level model.
    for (int k = 0; k < 40; k++) begin
      r   = $urandom;
      ins = {r[31:7], ops[$urandom_range(0, 9)]};
      vm  = 2'($urandom_range(1, 3));
      rt0 = TW'($urandom);
      rt1 = TW'($urandom);
      ref_imm(ins, eimm, eerr, ectrl);
      ewin = (vm == 2'b11) ? exp_rr : vm[1];
      transact("rand", vm, ewin ? ~ins : ins, ewin ? ins : ~ins, rt0, rt1,
               $urandom_range(0, 3), 1'($urandom), 1'($urandom), ewin, eimm, eerr, ectrl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
